// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter and its add-3 cell.
package bcd_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [3:0] BCD_ERR_DIGIT  = 4'hE;
   localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

   // Largest value representable in 'digits' decimal digits (10^digits - 1).
   function automatic int unsigned bcd_max_value(input int digits);
      int unsigned v;
      v = 1;
      for (int i = 0; i < digits; i++) begin
         v = v * 10;
      end
      return v - 1;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the next shift.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= ADD3_THRESHOLD) begin
         digit_o = digit_i + 4'd3;
      end
   end

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Sequential shift-add-3 binary to packed BCD converter, one bit per clock, with
// start/busy/done handshake and an all-4'hE error pattern for out-of-range inputs.
module binary_to_bcd_converter
   import bcd_pkg::*;
#(
   parameter int BIN_WIDTH = 14,
   parameter int DIGITS    = 4
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [BIN_WIDTH-1:0]   bin,
   output logic                   busy,
   output logic                   done,
   output logic [4*DIGITS-1:0]    bcd,
   output logic                   overflow
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);
   // Limit compare is wide enough to hold 10^8 - 1 regardless of BIN_WIDTH.
   localparam int LIM_W = (BIN_WIDTH > 27) ? BIN_WIDTH : 27;
   localparam logic [LIM_W-1:0] BIN_LIMIT = LIM_W'(bcd_max_value(DIGITS));

   state_t                 state_q, state_d;
   logic [BIN_WIDTH-1:0]   shift_q, shift_d;
   logic [BCD_W-1:0]       scratch_q, scratch_d, scratch_adj;
   logic [CNT_W-1:0]       cnt_q;
   logic                   ovf_flag_q;
   logic                   done_q;
   logic [BCD_W-1:0]       bcd_q;
   logic                   overflow_q;
   logic                   accept;
   logic                   last_iter;

   assign accept    = (state_q == IDLE) && start;
   assign last_iter = (state_q == SHIFT) && (cnt_q == CNT_W'(BIN_WIDTH - 1));

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
         bcd_add3 u_add3 (
            .digit_i (scratch_q[4*gi +: 4]),
            .digit_o (scratch_adj[4*gi +: 4])
         );
      end
   endgenerate

   // Corrected scratch and binary shift register move left together as one word.
   assign {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)     state_d = SHIFT;
         SHIFT:   if (last_iter) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == SHIFT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_flag_q <= 1'b0;
         done_q     <= 1'b0;
         bcd_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            shift_q    <= bin;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= (LIM_W'(bin) > BIN_LIMIT);
         end else if (state_q == SHIFT) begin
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_q + CNT_W'(1);
            if (last_iter) begin
               done_q     <= 1'b1;
               bcd_q      <= ovf_flag_q ? {DIGITS{BCD_ERR_DIGIT}} : scratch_d;
               overflow_q <= ovf_flag_q;
            end
         end
      end
   end

   assign done     = done_q;
   assign bcd      = bcd_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Scoreboard bench for binary_to_bcd_converter at default parameters (14-bit input, 4 digits).
module tb_binary_to_bcd_converter;

   localparam int BW = 14;
   localparam int DG = 4;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [BW-1:0] bin;
   logic          busy;
   logic          done;
   logic [4*DG-1:0] bcd;
   logic          overflow;

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   busy_run = 0;
   logic prev_done = 1'b0;
   logic [15:0] prev_bcd = 16'h0;

   binary_to_bcd_converter #(
      .BIN_WIDTH (BW),
      .DIGITS    (DG)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bin      (bin),
      .busy     (busy),
      .done     (done),
      .bcd      (bcd),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] exp_bcd(input int v);
      logic [15:0] r;
      int t;
      if (v > 9999) return 16'hEEEE;
      r = '0;
      t = v;
      for (int i = 0; i < DG; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Output monitor: every done pulse pops one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_run = 0;
         prev_bcd = bcd;
      end else begin
         if (done) begin
            $display("done: bcd=%h overflow=%b cycle=%0d", bcd, overflow, cyc);
            check("done_width", {63'd0, prev_done}, 64'd0);
            check("busy_on_done", {63'd0, busy}, 64'd0);
            if (sb.size() == 0) begin
               check("spurious_done", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("bcd", {48'd0, bcd}, {48'd0, e.bcd});
               check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
               check("latency", 64'(cyc - e.acc), 64'(BW));
               check("busy_cycles", 64'(busy_run), 64'(BW));
            end
            busy_run = 0;
         end else if (bcd !== prev_bcd) begin
            check("bcd_hold", {48'd0, bcd}, {48'd0, prev_bcd});
         end
         if (busy) busy_run++;
         prev_bcd = bcd;
      end
      prev_done = done;
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(posedge clk); #3;
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(posedge clk); #3;
         n++;
      end
      if (n >= 200) check("timeout", 64'd1, 64'd0);
   endtask

   task automatic start_conv(input int v, input bit push);
      exp_t e;
      @(negedge clk);
      bin   = BW'(v);
      start = 1'b1;
      if (push) begin
         e.bcd = exp_bcd(v);
         e.ovf = (v > 9999);
         e.acc = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check({tag, "_done"}, {63'd0, done}, 64'd0);
      check({tag, "_bcd"}, {48'd0, bcd}, 64'd0);
      check({tag, "_ovf"}, {63'd0, overflow}, 64'd0);
   endtask

   initial begin
      int k;
      exp_t e;
      rst_n = 1'b0;
      start = 1'b0;
      bin   = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Plain conversions including range limits and error substitution.
      wait_idle(); start_conv(1234, 1'b1); wait_idle();
      wait_idle(); start_conv(0, 1'b1);    wait_idle();
      wait_idle(); start_conv(9999, 1'b1); wait_idle();
      wait_idle(); start_conv(10000, 1'b1); wait_idle();
      wait_idle(); start_conv(16383, 1'b1); wait_idle();
      wait_idle(); start_conv(42, 1'b1);   wait_idle();

      // start and bin changes mid-conversion are ignored.
      wait_idle();
      start_conv(5678, 1'b1);
      repeat (4) @(negedge clk);
      bin   = BW'(1111);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bin   = '0;
      wait_idle();
      repeat (20) @(negedge clk);

      // start held high: a new conversion is accepted on each done cycle.
      wait_idle();
      @(negedge clk);
      bin   = BW'(7);
      start = 1'b1;
      k = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         e.bcd = 16'h0007;
         e.ovf = 1'b0;
         e.acc = k + i * (BW + 1);
         sb.push_back(e);
      end
      while (cyc < k + 2 * (BW + 1)) @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (20) @(negedge clk);

      // Reset mid-conversion aborts without a done pulse.
      wait_idle();
      start_conv(4321, 1'b0);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      start_conv(4321, 1'b1);
      wait_idle();
      repeat (3) @(negedge clk);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
